// File: rtl/multirate_updown_counter.sv
// Single-clock up/down counter stepped by a selectable-rate prescaler tick.
// Sel, Run and Clear come from board switches/buttons and are synchronized here.
module multirate_updown_counter #(
  parameter int WIDTH      = 4,
  parameter int SEL_W      = 2,
  parameter int BASE_SHIFT = 20,
  parameter int RATE_STEP  = 2
) (
  input  logic             FastClk,
  input  logic             Reset_n,
  input  logic [SEL_W-1:0] Sel,
  input  logic             Run,
  input  logic             Clear,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Count,
  output logic             Carry,
  output logic             Running
);

  localparam int PRESCALE_W = BASE_SHIFT + RATE_STEP * ((1 << SEL_W) - 1);

  logic [SEL_W-1:0]      sel_meta, sel_s, sel_prev;
  logic                  run_meta, run_s, run_prev;
  logic                  clear_meta, clear_s;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] tick_mask;
  logic                  sel_change;
  logic                  run_rise;
  logic                  tick;
  int                    n_bits;

  always_ff @(posedge FastClk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel_meta   <= '0;
      sel_s      <= '0;
      sel_prev   <= '0;
      run_meta   <= 1'b0;
      run_s      <= 1'b0;
      run_prev   <= 1'b0;
      clear_meta <= 1'b0;
      clear_s    <= 1'b0;
    end else begin
      sel_meta   <= Sel;
      sel_s      <= sel_meta;
      sel_prev   <= sel_s;
      run_meta   <= Run;
      run_s      <= run_meta;
      run_prev   <= run_s;
      clear_meta <= Clear;
      clear_s    <= clear_meta;
    end
  end

  // Tick fires when the low N(sel_s) prescaler bits are all ones.
  always_comb begin
    n_bits = BASE_SHIFT + RATE_STEP * int'(sel_s);
    for (int i = 0; i < PRESCALE_W; i++) begin
      tick_mask[i] = (i < n_bits);
    end
  end

  assign sel_change = (sel_s != sel_prev);
  assign run_rise   = run_s & ~run_prev;
  assign tick       = ((prescale & tick_mask) == tick_mask) && !sel_change;

  always_ff @(posedge FastClk or negedge Reset_n) begin
    if (!Reset_n) begin
      prescale <= '0;
    end else if (clear_s || Load || sel_change) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // A tick coinciding with a Run edge is judged against the pre-toggle Running.
  always_ff @(posedge FastClk or negedge Reset_n) begin
    if (!Reset_n) begin
      Running <= 1'b1;
    end else if (run_rise) begin
      Running <= ~Running;
    end
  end

  always_ff @(posedge FastClk or negedge Reset_n) begin
    if (!Reset_n) begin
      Count <= '0;
      Carry <= 1'b0;
    end else if (clear_s) begin
      Count <= '0;
      Carry <= 1'b0;
    end else if (Load) begin
      Count <= LoadValue;
      Carry <= 1'b0;
    end else if (tick && Running) begin
      if (Up) begin
        Count <= Count + 1'b1;
        Carry <= &Count;
      end else begin
        Count <= Count - 1'b1;
        Carry <= (Count == '0);
      end
    end
  end

endmodule

// File: tb/tb_multirate_updown_counter.sv
// Directed bench for multirate_updown_counter with fast rates (periods 2/4/8/16).
module tb_multirate_updown_counter;

  localparam int WIDTH = 4;
  localparam int SEL_W = 2;

  logic             clk;
  logic             rst_n;
  logic [SEL_W-1:0] sel;
  logic             run;
  logic             clear;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             running;

  int checks   = 0;
  int failures = 0;
  int j        = 0;

  multirate_updown_counter #(
    .WIDTH(WIDTH), .SEL_W(SEL_W), .BASE_SHIFT(1), .RATE_STEP(1)
  ) dut (
    .FastClk  (clk),
    .Reset_n  (rst_n),
    .Sel      (sel),
    .Run      (run),
    .Clear    (clear),
    .Up       (up),
    .Load     (load),
    .LoadValue(load_value),
    .Count    (count),
    .Carry    (carry),
    .Running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_to(input int n);
    while (j < n) begin
      @(negedge clk);
      j++;
    end
  endtask

  // Clear held long enough to pass the synchronizer; returns with prescaler at 0.
  task automatic restart(input logic [SEL_W-1:0] s, input logic u);
    sel   = s;
    up    = u;
    clear = 1'b1;
    repeat (5) @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    j = 0;
  endtask

  initial begin
    rst_n = 1'b1; sel = '0; run = 1'b0; clear = 1'b0; up = 1'b1;
    load = 1'b0; load_value = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_carry", carry, 0);
    check("rst_running", running, 1);

    // Sel=0 up-count from release through the 15->0 wrap.
    rst_n = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      @(negedge clk);
      check("up_count", count, (e / 2) % 16);
      check("up_carry", carry, (e == 32 || e == 33) ? 1 : 0);
      check("up_running", running, 1);
    end

    // Sel=3 down-count: borrow from 0.
    restart(2'd3, 1'b0);
    check("dn_start", count, 0);
    run_to(15); check("dn_before", count, 0);
    run_to(16); check("dn_wrap_count", count, 15); check("dn_wrap_carry", carry, 1);
    run_to(31); check("dn_hold_count", count, 15); check("dn_hold_carry", carry, 1);
    run_to(32); check("dn_next_count", count, 14); check("dn_next_carry", carry, 0);

    // Sel 0->2 mid-period: change cycle suppresses the tick.
    restart(2'd0, 1'b1);
    run_to(5); check("sel_pre", count, 2);
    sel = 2'd2;
    run_to(6); check("sel_last_fast", count, 3);
    run_to(8); check("sel_suppressed", count, 3);
    run_to(15); check("sel_wait", count, 3);
    run_to(16); check("sel_first_slow", count, 4);

    // Run pulses: pause, freeze, resume; long hold toggles once.
    restart(2'd0, 1'b1);
    run_to(2); run = 1'b1;
    run_to(3); run = 1'b0;
    run_to(4); check("pause_pre_running", running, 1); check("pause_pre_count", count, 2);
    run_to(5); check("pause_running", running, 0);
    for (int k = 6; k <= 25; k++) begin
      run_to(k); check("pause_frozen", count, 2);
    end
    run = 1'b1;
    run_to(26); run = 1'b0;
    run_to(27); check("resume_pre", running, 0);
    run_to(28); check("resume_running", running, 1); check("resume_tick_dropped", count, 2);
    run_to(30); check("resume_count", count, 3);
    run = 1'b1;
    run_to(32); check("hold_count", count, 4);
    run_to(33); check("hold_toggle", running, 0);
    run_to(40); run = 1'b0;
    run_to(45); check("hold_once", running, 0); check("hold_frozen", count, 4);

    // Load while paused, then Clear over Load.
    load = 1'b1; load_value = 4'd9;
    run_to(46); check("load_count", count, 9); check("load_carry", carry, 0);
    clear = 1'b1; load_value = 4'd5;
    run_to(47); check("load_before_clear", count, 5);
    run_to(49); check("clear_over_load", count, 0);
    run_to(50); check("clear_over_load_held", count, 0);
    clear = 1'b0; load = 1'b0;

    // Resume, count down to a borrow, then reset asynchronously.
    run_to(52); run = 1'b1; up = 1'b0;
    run_to(53); run = 1'b0;
    run_to(54); check("rs_paused", running, 0);
    run_to(55); check("rs_running", running, 1);
    run_to(56); check("rs_count", count, 15); check("rs_carry", carry, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_carry", carry, 0);
    check("async_running", running, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
